// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake bundle between operand fetch, the sequential ALU and
// writeback.
//   in_valid/in_ready   : operand-side handshake (transfer when both high)
//   mode, a, b          : operation select and operands
//   out_valid/out_ready : result-side handshake (transfer when both high)
//   result, flag_z/c/v  : operation result and status flags
// The master modport is the side that drives operands and consumes results;
// the slave modport is the ALU itself.
interface alu_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;

   modport master (
      output in_valid, mode, a, b, out_ready,
      input  in_ready, out_valid, result, flag_z, flag_c, flag_v
   );

   modport slave (
      input  in_valid, mode, a, b, out_ready,
      output in_ready, out_valid, result, flag_z, flag_c, flag_v
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arith/shift/compare ops and
// iterative (one bit per cycle) multiply and unsigned divide/remainder.
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_seq_if slave side (in_valid/in_ready/mode/a/b in,
//            out_valid/out_ready/result/flag_z/flag_c/flag_v out)
// Modes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA,
// 9 SLT, 10 SLTU, 11 MUL, 12 MULHU, 13 DIVU, 14 REMU, 15 reserved (0).
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state;
   state_t             state_next;
   logic [3:0]         mode_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_step;
   logic [SHW-1:0]     cnt;
   logic               accept;
   logic               iter_in;
   logic               mul_q;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [WIDTH:0]     add_full;
   logic [WIDTH:0]     sub_full;
   logic [SHW-1:0]     sh;
   logic [WIDTH-1:0]   res;
   logic               carry;
   logic               ovf;

   // The only combinational path through the unit: a waiting result that is
   // being taken this cycle frees the unit for a new op in the same cycle.
   assign bus.in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign iter_in      = (bus.mode >= 4'd11) && (bus.mode <= 4'd14);
   assign mul_q        = (mode_q == 4'd11) || (mode_q == 4'd12);
   assign sh           = b_q[SHW-1:0];
   assign bus.out_valid = (state == DONE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: iterative ops park in BUSY until the step counter has
   // run out, everything else goes straight to DONE. A result taken while a
   // new op is offered chains directly into that op.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = iter_in ? BUSY : DONE;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  state_next = iter_in ? BUSY : DONE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture and iterative engine. acc is shared: for multiply it is
   // {partial product, remaining multiplier bits}, for divide it is
   // {partial remainder, dividend bits shifting into quotient bits}.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= '0;
         a_q    <= '0;
         b_q    <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (accept) begin
         mode_q <= bus.mode;
         a_q    <= bus.a;
         b_q    <= bus.b;
         acc    <= {{WIDTH{1'b0}}, bus.a};
         if (iter_in) begin
            cnt <= SHW'(WIDTH - 1);
         end
      end else if (state == BUSY) begin
         acc <= acc_step;
         if (cnt != '0) begin
            cnt <= cnt - SHW'(1);
         end
      end
   end

   // One radix-2 step. Multiply adds the multiplicand when the current low
   // bit is set and shifts the whole product right. Divide shifts the next
   // dividend bit into the remainder and restores on borrow; with b = 0 every
   // trial succeeds, so the quotient ends all ones and the remainder ends as a.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_q};
      acc_step  = acc;
      if (mul_q) begin
         acc_step = {mul_sum, acc[WIDTH-1:1]};
      end else if (!div_diff[WIDTH]) begin
         acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end

   // Result and flag selection from the captured operands (single-cycle ops)
   // or from the finished engine state (iterative ops). SUB carry is the
   // inverted borrow, so it reads as "a >= b unsigned".
   always_comb begin
      add_full = {1'b0, a_q} + {1'b0, b_q};
      sub_full = {1'b0, a_q} - {1'b0, b_q};
      res      = '0;
      carry    = 1'b0;
      ovf      = 1'b0;
      case (mode_q)
         4'd1: begin
            res   = add_full[WIDTH-1:0];
            carry = add_full[WIDTH];
            ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
         end
         4'd2: begin
            res   = sub_full[WIDTH-1:0];
            carry = !sub_full[WIDTH];
            ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
         end
         4'd3:  res = a_q & b_q;
         4'd4:  res = a_q | b_q;
         4'd5:  res = a_q ^ b_q;
         4'd6:  res = a_q << sh;
         4'd7:  res = a_q >> sh;
         4'd8:  res = $signed(a_q) >>> sh;
         4'd9:  res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         4'd10: res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
         4'd11: res = acc[WIDTH-1:0];
         4'd12: res = acc[2*WIDTH-1:WIDTH];
         4'd13: res = acc[WIDTH-1:0];
         4'd14: res = acc[2*WIDTH-1:WIDTH];
         default: res = '0;
      endcase
   end

   // Outputs read as zero whenever no result is being presented; while held
   // in DONE nothing feeding res can change, so result and flags stay put.
   assign bus.result = (state == DONE) ? res : '0;
   assign bus.flag_z = (state == DONE) && (res == '0);
   assign bus.flag_c = (state == DONE) && carry;
   assign bus.flag_v = (state == DONE) && ovf;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH = 32). Expected results
// are pushed to a scoreboard queue as each op is driven and popped when the
// DUT presents its result.
module tb_alu_seq;

   localparam int WIDTH = 32;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  zcv;
      int          lat;
   } exp_t;

   typedef struct packed {
      logic [3:0]  m;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [2:0]  zcv;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   vec_t single_tab [14] = '{
      '{4'd1,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 3'b001},
      '{4'd1,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 3'b110},
      '{4'd2,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 3'b000},
      '{4'd2,  32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 3'b010},
      '{4'd2,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 3'b011},
      '{4'd8,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 3'b000},
      '{4'd6,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 3'b000},
      '{4'd7,  32'h8000_0000, 32'hFFFF_FFE1, 32'h4000_0000, 3'b000},
      '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 3'b000},
      '{4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 3'b100},
      '{4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 3'b000},
      '{4'd5,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 3'b100},
      '{4'd0,  32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 3'b100},
      '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 3'b100}
   };

   vec_t iter_tab [7] = '{
      '{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3'b000},
      '{4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'b000},
      '{4'd13, 32'd100,       32'd7,         32'd14,        3'b000},
      '{4'd14, 32'd100,       32'd7,         32'd2,         3'b000},
      '{4'd13, 32'h0000_0055, 32'h0000_0000, 32'hFFFF_FFFF, 3'b000},
      '{4'd14, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 3'b000},
      '{4'd11, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 3'b100}
   };

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(WIDTH)) bus ();

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference behaviour written from the operation list, using the
   // language's own multiply/divide rather than any bit-serial scheme.
   function automatic exp_t model(input logic [3:0] m, input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      logic [32:0] t;
      logic [63:0] p;
      e.res = '0;
      e.zcv = '0;
      p     = {32'b0, x} * {32'b0, y};
      case (m)
         4'd1: begin
            t        = {1'b0, x} + {1'b0, y};
            e.res    = t[31:0];
            e.zcv[1] = t[32];
            e.zcv[0] = (x[31] == y[31]) && (e.res[31] != x[31]);
         end
         4'd2: begin
            e.res    = x - y;
            e.zcv[1] = (x >= y);
            e.zcv[0] = (x[31] != y[31]) && (e.res[31] != x[31]);
         end
         4'd3:  e.res = x & y;
         4'd4:  e.res = x | y;
         4'd5:  e.res = x ^ y;
         4'd6:  e.res = x << y[4:0];
         4'd7:  e.res = x >> y[4:0];
         4'd8:  e.res = $signed(x) >>> y[4:0];
         4'd9:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd10: e.res = (x < y) ? 32'd1 : 32'd0;
         4'd11: e.res = p[31:0];
         4'd12: e.res = p[63:32];
         4'd13: e.res = (y == 0) ? 32'hFFFF_FFFF : x / y;
         4'd14: e.res = (y == 0) ? x : x % y;
         default: e.res = '0;
      endcase
      e.zcv[2] = (e.res == 32'd0);
      e.lat    = (m >= 4'd11 && m <= 4'd14) ? WIDTH + 1 : 1;
      return e;
   endfunction

   function automatic exp_t from_vec(input vec_t v);
      exp_t e;
      e.res = v.r;
      e.zcv = v.zcv;
      e.lat = (v.m >= 4'd11 && v.m <= 4'd14) ? WIDTH + 1 : 1;
      return e;
   endfunction

   // Offer one op and return in the cycle after it was accepted; inputs are
   // then scrambled so an op in flight must not depend on them.
   task automatic send(input logic [3:0] m, input logic [31:0] x, input logic [31:0] y);
      int t;
      t = 0;
      bus.mode     = m;
      bus.a        = x;
      bus.b        = y;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!bus.in_ready) begin
         tests++;
         fails++;
         $display("[TB] FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, t);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.mode     = 4'($urandom);
      bus.a        = $urandom;
      bus.b        = $urandom;
   endtask

   // Wait (bounded) for out_valid, counting cycles since the accepting cycle,
   // then take the result with out_ready (assumed high).
   task automatic wait_result(output logic [31:0] r, output logic [2:0] zcv, output int lat,
                              output bit busy_rdy);
      lat      = 1;
      busy_rdy = 1'b0;
      while (!bus.out_valid && lat < 200) begin
         if (bus.in_ready) busy_rdy = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      r   = bus.result;
      zcv = {bus.flag_z, bus.flag_c, bus.flag_v};
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      logic [2:0]  zcv;
      int          lat;
      bit          busy_rdy;
      int          seen;
      exp_t        e;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.mode      = '0;
      bus.a         = '0;
      bus.b         = '0;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({bus.in_ready, bus.out_valid, bus.result, bus.flag_z, bus.flag_c, bus.flag_v} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
         fails++;
         $display("[TB] FAIL reset_state: rdy=%b vld=%b res=%h zcv=%b%b%b, required rdy=1 vld=0 res=0 zcv=000",
                  bus.in_ready, bus.out_valid, bus.result, bus.flag_z, bus.flag_c, bus.flag_v);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(4'd13, 32'd100, 32'd7);
      repeat (8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({bus.in_ready, bus.out_valid, bus.result, bus.flag_z, bus.flag_c, bus.flag_v} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
         fails++;
         $display("[TB] FAIL reset_mid_divu: rdy=%b vld=%b res=%h zcv=%b%b%b, required rdy=1 vld=0 res=0 zcv=000",
                  bus.in_ready, bus.out_valid, bus.result, bus.flag_z, bus.flag_c, bus.flag_v);
      end
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      seen  = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      tests++;
      if (seen !== 0) begin
         fails++;
         $display("[TB] FAIL reset_discard: out_valid seen %0d cycles, required 0", seen);
      end
      sb.push_back(model(4'd1, 32'd1, 32'd2));
      send(4'd1, 32'd1, 32'd2);
      wait_result(r, zcv, lat, busy_rdy);
      e = sb.pop_front();
      tests++;
      if ({r, zcv} !== {e.res, e.zcv} || r !== 32'd3) begin
         fails++;
         $display("[TB] FAIL reset_then_add: res=%h zcv=%b, required res=%h zcv=%b", r, zcv, e.res, e.zcv);
      end
      tests++;
      if (lat !== 1) begin
         fails++;
         $display("[TB] FAIL reset_then_add_latency: latency=%0d, required 1", lat);
      end
   endtask

   task automatic test_single_cycle();
      logic [31:0] r;
      logic [2:0]  zcv;
      int          lat;
      bit          busy_rdy;
      exp_t        e;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         sb.push_back(from_vec(single_tab[i]));
         send(single_tab[i].m, single_tab[i].a, single_tab[i].b);
         wait_result(r, zcv, lat, busy_rdy);
         e = sb.pop_front();
         tests++;
         if ({r, zcv} !== {e.res, e.zcv}) begin
            fails++;
            $display("[TB] FAIL single[%0d] mode %0d: res=%h zcv=%b, required res=%h zcv=%b",
                     i, single_tab[i].m, r, zcv, e.res, e.zcv);
         end
         tests++;
         if (lat !== e.lat) begin
            fails++;
            $display("[TB] FAIL single_latency[%0d]: latency=%0d, required %0d", i, lat, e.lat);
         end
      end
   endtask

   task automatic test_iterative();
      logic [31:0] r;
      logic [2:0]  zcv;
      int          lat;
      bit          busy_rdy;
      exp_t        e;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         sb.push_back(from_vec(iter_tab[i]));
         send(iter_tab[i].m, iter_tab[i].a, iter_tab[i].b);
         wait_result(r, zcv, lat, busy_rdy);
         e = sb.pop_front();
         tests++;
         if ({r, zcv} !== {e.res, e.zcv}) begin
            fails++;
            $display("[TB] FAIL iter[%0d] mode %0d: res=%h zcv=%b, required res=%h zcv=%b",
                     i, iter_tab[i].m, r, zcv, e.res, e.zcv);
         end
         tests++;
         if (lat !== e.lat) begin
            fails++;
            $display("[TB] FAIL iter_latency[%0d]: latency=%0d, required %0d", i, lat, e.lat);
         end
         tests++;
         if (busy_rdy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL iter_busy_ready[%0d]: in_ready seen high while busy=%b, required 0", i, busy_rdy);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic [2:0]  zcv;
      int          lat;
      bit          busy_rdy;
      exp_t        e;
      logic [3:0]  m;
      logic [31:0] x;
      logic [31:0] y;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         m = 4'($urandom_range(0, 15));
         x = $urandom;
         y = (i % 4 == 3) ? 32'd0 : $urandom;
         sb.push_back(model(m, x, y));
         send(m, x, y);
         wait_result(r, zcv, lat, busy_rdy);
         e = sb.pop_front();
         tests++;
         if ({r, zcv} !== {e.res, e.zcv} || lat !== e.lat) begin
            fails++;
            $display("[TB] FAIL random[%0d] mode %0d a=%h b=%h: res=%h zcv=%b lat=%0d, required res=%h zcv=%b lat=%0d",
                     i, m, x, y, r, zcv, lat, e.res, e.zcv, e.lat);
         end
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   bad;
      bus.out_ready = 1'b0;
      sb.push_back(model(4'd1, 32'h7FFF_FFFF, 32'h0000_0001));
      send(4'd1, 32'h7FFF_FFFF, 32'h0000_0001);
      e   = sb.pop_front();
      bad = 0;
      repeat (5) begin
         if (!bus.out_valid || bus.in_ready || bus.result !== e.res ||
             {bus.flag_z, bus.flag_c, bus.flag_v} !== e.zcv) bad++;
         @(posedge clk); #1;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("[TB] FAIL backpressure_hold: %0d unstable cycles (last vld=%b rdy=%b res=%h), required 0 (vld=1 rdy=0 res=%h)",
                  bad, bus.out_valid, bus.in_ready, bus.result, e.res);
      end
      sb.push_back(model(4'd2, 32'd9, 32'd4));
      bus.mode      = 4'd2;
      bus.a         = 32'd9;
      bus.b         = 32'd4;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      tests++;
      if (bus.in_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL backpressure_release_ready: in_ready=%b, required 1", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      e = sb.pop_front();
      tests++;
      if (bus.out_valid !== 1'b1 || bus.result !== e.res || {bus.flag_z, bus.flag_c, bus.flag_v} !== e.zcv) begin
         fails++;
         $display("[TB] FAIL backpressure_chain: vld=%b res=%h zcv=%b%b%b, required vld=1 res=%h zcv=%b",
                  bus.out_valid, bus.result, bus.flag_z, bus.flag_c, bus.flag_v, e.res, e.zcv);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      logic [31:0] x;
      logic [31:0] y;
      bus.out_ready = 1'b1;
      for (int i = 0; i <= 6; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++;
            if (bus.out_valid !== 1'b1 || bus.result !== e.res || {bus.flag_z, bus.flag_c, bus.flag_v} !== e.zcv) begin
               fails++;
               $display("[TB] FAIL back_to_back[%0d]: vld=%b res=%h zcv=%b%b%b, required vld=1 res=%h zcv=%b",
                        i - 1, bus.out_valid, bus.result, bus.flag_z, bus.flag_c, bus.flag_v, e.res, e.zcv);
            end
         end
         if (i < 6) begin
            x = $urandom;
            y = $urandom;
            sb.push_back(model(4'd1, x, y));
            bus.mode     = 4'd1;
            bus.a        = x;
            bus.b        = y;
            bus.in_valid = 1'b1;
            tests++;
            if (bus.in_ready !== 1'b1) begin
               fails++;
               $display("[TB] FAIL back_to_back_ready[%0d]: in_ready=%b, required 1", i, bus.in_ready);
            end
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single_cycle();
      test_iterative();
      test_random();
      test_backpressure();
      test_back_to_back();
      tests++;
      if (sb.size() !== 0) begin
         fails++;
         $display("[TB] FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
